bcd_gate_counter_ctrl: RTL and testbench

Gated event counter controller built around a cascade of BCD decade counters with sync clear, enable, TC and CEO.
- Sequences the cascade: sync clear, open a fixed gate window, count events, latch the BCD result, then idle or restart.
- Used as the measurement core for frequency and event-rate displays feeding the 7-segment/display logic.

---
 rtl/bcd_gate_pkg.sv | 14 +
 rtl/bcd_gate_counter_ctrl_digit.sv | 28 ++
 rtl/bcd_gate_counter_ctrl.sv | 119 +++++++++++
 tb/tb_bcd_gate_counter_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_gate_pkg.sv
// Shared types and constants for the gated BCD event counter.
package bcd_gate_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        GATE,
        LATCH
    } state_t;

endpackage

// File: rtl/bcd_gate_counter_ctrl_digit.sv
// One BCD decade: counts 0..9 on ce, wraps 9->0, sync clear, TC and CEO for cascading.
module bcd_digit
    import bcd_gate_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ce,
    output logic [BCD_W-1:0] q,
    output logic             tc,
    output logic             ceo
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (ce) begin
            q <= (q == BCD_MAX) ? '0 : q + BCD_W'(1);
        end
    end

    assign tc  = (q == BCD_MAX);
    assign ceo = tc & ce;

endmodule

// File: rtl/bcd_gate_counter_ctrl.sv
// Gated BCD event counter controller: IDLE -> CLEAR -> GATE -> LATCH, optional repeat.
// Define SYNC_EVT_EN to count synchronized rising edges of evt instead of per-cycle levels.
module bcd_gate_counter_ctrl
    import bcd_gate_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int GATE_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    cont,
    input  logic                    evt,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf,
    output logic [BCD_W*DIGITS-1:0] bcd
);

    localparam int TW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;

    state_t                  state;
    logic [TW-1:0]           timer;
    logic                    sticky_ovf;
    logic                    evt_cnt;
    logic                    clr;
    logic [DIGITS-1:0]       ce;
    logic [DIGITS-1:0]       tc;
    logic [DIGITS-1:0]       ceo;
    logic [BCD_W*DIGITS-1:0] cascade;
    logic                    unused_tc;

`ifdef SYNC_EVT_EN
    logic [2:0] evt_sync;
    logic       evt_rise;

    // Synchronizer keeps running through CLEAR so an edge straddling windows is not lost or doubled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_sync <= '0;
            evt_rise <= 1'b0;
        end else begin
            evt_sync <= {evt_sync[1:0], evt};
            evt_rise <= evt_sync[1] & ~evt_sync[2];
        end
    end

    assign evt_cnt = evt_rise;
`else
    assign evt_cnt = evt;
`endif

    assign clr   = (state == CLEAR);
    assign ce[0] = evt_cnt & (state == GATE);

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        if (i > 0) begin : g_chain
            assign ce[i] = ceo[i-1];
        end
        bcd_digit u_digit (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .ce    (ce[i]),
            .q     (cascade[BCD_W*i +: BCD_W]),
            .tc    (tc[i]),
            .ceo   (ceo[i])
        );
    end

    // Per-digit TC is only consumed inside each decade's CEO here.
    assign unused_tc = ^tc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            sticky_ovf <= 1'b0;
            bcd        <= '0;
            ovf        <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    timer      <= TW'(GATE_CYCLES - 1);
                    sticky_ovf <= 1'b0;
                    state      <= GATE;
                end
                GATE: begin
                    // Top-decade carry means the window exceeded the displayable range.
                    if (ceo[DIGITS-1]) sticky_ovf <= 1'b1;
                    if (timer == '0) state <= LATCH;
                    else             timer <= timer - TW'(1);
                end
                LATCH: begin
                    bcd  <= cascade;
                    ovf  <= sticky_ovf;
                    done <= 1'b1;
                    if (cont) begin
                        state <= CLEAR;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_gate_counter_ctrl.sv
// Scoreboard bench: DIGITS=2/GATE=20 and DIGITS=1/GATE=12 instances sharing clk, rst_n and evt.
module tb_bcd_gate_counter_ctrl;

    localparam int G2 = 20;
    localparam int G1 = 12;

    typedef struct {
        logic [7:0] bcd;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0, start2 = 1'b0;
    logic       cont1 = 1'b0, cont2 = 1'b0;
    logic       evt = 1'b0;
    logic       busy1, busy2, done1, done2, ovf1, ovf2;
    logic [3:0] bcd1;
    logic [7:0] bcd2;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    bcd_gate_counter_ctrl #(.DIGITS(2), .GATE_CYCLES(G2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .cont(cont2), .evt(evt),
        .busy(busy2), .done(done2), .ovf(ovf2), .bcd(bcd2)
    );

    bcd_gate_counter_ctrl #(.DIGITS(1), .GATE_CYCLES(G1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .cont(cont1), .evt(evt),
        .busy(busy1), .done(done1), .ovf(ovf1), .bcd(bcd1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // evt level presented to edge k counted from the start (or previous LATCH) edge.
    function automatic logic pat(input int mode, input int k);
        case (mode)
            1:       return 1'b1;
            2:       return (k % 2 == 0);
            3:       return (k >= 0) && (k % 6 < 5);
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t model(input int mode, input int g, input int digits);
        exp_t e;
        int   cnt = 0;
        int   lim = 1;
        int   v;
`ifdef SYNC_EVT_EN
        for (int k = 0; k <= g - 2; k++)
            if (pat(mode, k) && !(k > 0 && pat(mode, k - 1))) cnt++;
`else
        for (int k = 2; k <= g + 1; k++)
            if (pat(mode, k)) cnt++;
`endif
        for (int i = 0; i < digits; i++) lim *= 10;
        e.ovf = (cnt >= lim);
        v = cnt % lim;
        e.bcd = '0;
        for (int i = 0; i < digits; i++) begin
            e.bcd[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return e;
    endfunction

    task automatic measure(input int dut, input int mode, input bit do_start,
                           input bit spam, input bit exp_idle, input int drop_at);
        int   g = (dut == 1) ? G1 : G2;
        int   n = 0;
        bit   seen = 0;
        exp_t e;
        sb.push_back(model(mode, g, (dut == 1) ? 1 : 2));
        if (do_start) begin
            evt = pat(mode, 0);
            if (dut == 1) start1 = 1'b1; else start2 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            start2 = 1'b0;
        end
        evt = pat(mode, 1);
        while (n < 200 && !seen) begin
            @(negedge clk);
            n++;
            evt = pat(mode, n + 1);
            if (spam) start2 = (n < 15) && (n % 3 == 0);
            if (n == drop_at) cont2 = 1'b0;
            seen = (dut == 1) ? done1 : done2;
        end
        start2 = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
        e = sb.pop_front();
        if (seen) begin
            check("latency", n, g + 2);
            check("bcd", (dut == 1) ? {24'h0, 4'h0, bcd1} : {24'h0, bcd2}, {24'h0, e.bcd});
            check("ovf", 32'((dut == 1) ? ovf1 : ovf2), 32'(e.ovf));
            check("busy_after", 32'((dut == 1) ? busy1 : busy2), 32'(!exp_idle));
            if (exp_idle) begin
                @(negedge clk);
                check("done_pulse", 32'((dut == 1) ? done1 : done2), 32'd0);
            end
        end
    endtask

    task automatic quiet(input int cycles, input string tag);
        int dones = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done2) dones++;
        end
        check(tag, dones, 0);
        check({tag, "_busy"}, 32'(busy2), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_bcd2", {24'h0, bcd2}, 32'h0);
        check("rst_ovf2", 32'(ovf2), 32'd0);
        check("rst_done2", 32'(done2), 32'd0);
        check("rst_busy2", 32'(busy2), 32'd0);
        check("rst_bcd1", {28'h0, bcd1}, 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

`ifdef SYNC_EVT_EN
        measure(2, 3, 1, 0, 1, -1);
        evt = 1'b0;
        repeat (6) @(negedge clk);
        measure(1, 0, 1, 0, 1, -1);
`else
        measure(2, 1, 1, 0, 1, -1);
        evt = 1'b0;
        repeat (3) @(negedge clk);
        measure(2, 2, 1, 0, 1, -1);
        measure(1, 1, 1, 0, 1, -1);
        measure(1, 0, 1, 0, 1, -1);

        cont2 = 1'b1;
        measure(2, 1, 1, 0, 0, -1);
        measure(2, 1, 0, 0, 0, -1);
        measure(2, 1, 0, 0, 1, 5);
        quiet(30, "cont_drop_idle");

        evt = 1'b1;
        measure(2, 1, 1, 1, 1, -1);
        quiet(5, "spam_idle");

        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (10) @(negedge clk);
        check("gate_busy", 32'(busy2), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_bcd", {24'h0, bcd2}, 32'h0);
        check("midrst_busy", 32'(busy2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet(30, "midrst_nodone");
        measure(2, 1, 1, 0, 1, -1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
